// File: rtl/regs_pkg.sv
// Shared register-file types and default geometry for decode, issue and writeback.
package regs_pkg;
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int REGS_DATA_W = 16;
  localparam int REGS_ADDR_W = 4;
  localparam int REGS_NREAD  = 2;
endpackage

// File: rtl/regs_scoreboard.sv
// Per-register busy bits: mark sets, write clears, mark wins on collision.
// Read lookup treats a same-cycle write as resolving the hazard unless also re-marked.
module regs_scoreboard #(
  parameter int ADDR_W = 4,
  parameter int NREAD  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mark_en_i,
  input  logic [ADDR_W-1:0]       mark_addr_i,
  input  logic                    clr_en_i,
  input  logic [ADDR_W-1:0]       clr_addr_i,
  input  logic [NREAD*ADDR_W-1:0] raddr_q_i,
  output logic [NREAD-1:0]        rbusy_o
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) busy_d[clr_addr_i] = 1'b0;
    if (mark_en_i) busy_d[mark_addr_i] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_port
    logic [ADDR_W-1:0] a;
    logic              wm, mm;
    assign a  = raddr_q_i[k*ADDR_W +: ADDR_W];
    assign wm = clr_en_i && (clr_addr_i == a);
    assign mm = mark_en_i && (mark_addr_i == a);
    assign rbusy_o[k] = wm ? mm : busy_q[a];
  end
endmodule

// File: rtl/regs_mp.sv
// Multi-port register file with write forwarding, busy scoreboard and post-reset zero sweep.
// Optional REGS_R0_ZERO_EN makes entry 0 a hardwired zero that is never busy.
module regs_mp
  import regs_pkg::*;
#(
  parameter int DATA_W = REGS_DATA_W,
  parameter int ADDR_W = REGS_ADDR_W,
  parameter int NREAD  = REGS_NREAD
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREAD*ADDR_W-1:0] raddr_,
  output logic [NREAD*DATA_W-1:0] rdata,
  output logic [NREAD-1:0]        rbusy,
  input  logic                    wen,
  input  logic [ADDR_W-1:0]       waddr,
  input  logic [DATA_W-1:0]       wdata,
  input  logic                    mark_en,
  input  logic [ADDR_W-1:0]       mark_addr,
  output logic                    ready
);
  localparam int DEPTH = 1 << ADDR_W;

  state_e                    state_q, state_d;
  logic [ADDR_W:0]           cnt_q, cnt_d;
  logic [NREAD*ADDR_W-1:0]   raddr_q;
  logic [DATA_W-1:0]         mem [DEPTH];
  logic                      run, wr_ok, mk_ok, wr_en, mk_en;
  logic [NREAD-1:0]          sb_busy;

  assign run = (state_q == ST_RUN);

`ifdef REGS_R0_ZERO_EN
  assign wr_ok = wen && (waddr != '0);
  assign mk_ok = mark_en && (mark_addr != '0);
`else
  assign wr_ok = wen;
  assign mk_ok = mark_en;
`endif

  assign wr_en = run && wr_ok;
  assign mk_en = run && mk_ok;
  assign ready = run;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + {{ADDR_W{1'b0}}, 1'b1};
        // Top bit of the widened counter flags that the last entry was just cleared.
        if (cnt_d[ADDR_W]) state_d = ST_RUN;
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      raddr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      raddr_q <= raddr_;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (!run)       mem[cnt_q[ADDR_W-1:0]] <= '0;
      else if (wr_en) mem[waddr] <= wdata;
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] val;
    assign a = raddr_q[k*ADDR_W +: ADDR_W];
`ifdef REGS_R0_ZERO_EN
    assign val = (a == '0) ? '0 : ((wr_en && (waddr == a)) ? wdata : mem[a]);
`else
    assign val = (wr_en && (waddr == a)) ? wdata : mem[a];
`endif
    assign rdata[k*DATA_W +: DATA_W] = run ? val : '0;
    assign rbusy[k] = run && sb_busy[k];
  end

  regs_scoreboard #(
    .ADDR_W(ADDR_W),
    .NREAD (NREAD)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .mark_en_i  (mk_en),
    .mark_addr_i(mark_addr),
    .clr_en_i   (wr_en),
    .clr_addr_i (waddr),
    .raddr_q_i  (raddr_q),
    .rbusy_o    (sb_busy)
  );
endmodule

// File: doc/regs_mp.md
Name: regs_mp

Overview:
- Parametrised successor to the 16x16 two-read/one-write CPU register file in the pipeline decode stage.
- Adds configurable width, depth and read-port count.
- Adds write-to-read forwarding, a per-register busy scoreboard for hazard detection, and a post-reset zeroing sweep with a ready flag.
- Feeds operand data and busy status to the decode/issue stage; the writeback stage drives the write port.

Parameters:
DATA_W, 16, register width in bits
ADDR_W, 4, register index width; DEPTH = 2**ADDR_W entries
NREAD, 2, number of read ports (1..4)

Ports:
clk  in  1  clock, all state on posedge
rst_n  in  1  synchronous active-low reset
raddr_  in  NREAD*ADDR_W  read addresses, port k at [k*ADDR_W +: ADDR_W], captured each posedge
rdata  out  NREAD*DATA_W  read data, port k at [k*DATA_W +: DATA_W]
rbusy  out  NREAD  busy flag of the register addressed by each captured read address
wen  in  1  write enable
waddr  in  ADDR_W  write index
wdata  in  DATA_W  write data
mark_en  in  1  set busy bit of mark_addr (instruction issued with this destination)
mark_addr  in  ADDR_W  destination index to mark
ready  out  1  high once the init sweep has completed

Behaviour:
- States: INIT, RUN. Reset (rst_n=0 at posedge) puts the block in INIT with sweep counter=0, all busy bits=0, all captured read addresses=0, and ready=0.
- Reset applied mid-operation behaves identically: any in-flight mark or write at that edge is discarded.
- INIT:
  - Each cycle with rst_n=1, write 0 into entry[counter], then counter+1.
  - After entry DEPTH-1 is written, go to RUN; ready=1 from the next cycle. The sweep takes DEPTH cycles after reset release.
  - wen and mark_en are ignored.
  - rdata=0 and rbusy=0 on all ports.
  - Read addresses are still captured.
- RUN, read:
  - raddr_ is registered at posedge (1-cycle address latency).
  - rdata port k = entry[raddr_q_k], combinational from the array.
  - Forwarding: if wen=1 and waddr==raddr_q_k in the same cycle, rdata port k = wdata (same-cycle writeback visible).
  - All ports are independent; several ports may read the same index.
- RUN, write:
  - wen=1 writes wdata to entry[waddr] at posedge.
  - The same write clears busy[waddr].
- RUN, scoreboard:
  - mark_en=1 sets busy[mark_addr] at posedge.
  - mark_en and wen to the same index in the same cycle: busy ends set (new producer wins); data is still written.
  - rbusy port k = busy[raddr_q_k] AND NOT (wen AND waddr==raddr_q_k), i.e. the same-cycle write is treated as resolving the hazard.
  - Exception: if that same cycle also marks raddr_q_k, rbusy=1.
- Widths: no arithmetic on data; the sweep counter is ADDR_W+1 bits so that wrap at DEPTH is detected without overflow.
- Outputs after reset: rdata=0, rbusy=0, ready=0.

Optional Feature:
REGS_R0_ZERO_EN:
- Defined:
  - Entry 0 reads as 0 on every port, with no forwarding for index 0.
  - Writes to index 0 are dropped.
  - busy[0] is never set and rbusy reads 0 for index 0.
- Undefined: entry 0 is an ordinary register.

Decomposition:
- Package regs_pkg: state enum (INIT, RUN) and default width/depth constants shared with decode and writeback.
- Sub-module regs_scoreboard: busy vector with mark/clear/reset, and per-port rbusy lookup with same-cycle resolution.
- The array, forwarding and init FSM stay in regs_mp.

Test Plan:
- Reset then release -> ready=0 for exactly 16 cycles, then ready=1; every read of indices 0..15 returns 0x0000.
- RUN: write r3=0xBEEF; next cycle raddr_0=3 -> after the capture edge, rdata port 0 = 0xBEEF.
- Forwarding: raddr_1=5 captured; in the following cycle wen=1, waddr=5, wdata=0x1234 -> rdata port 1 = 0x1234 in that same cycle, before the write edge.
- Scoreboard:
  - Mark r7, then capture raddr_0=7 -> rbusy[0]=1.
  - Later cycle with wen to r7 -> rbusy[0]=0 in that cycle; busy stays clear afterwards.
  - Mark and write r7 in the same cycle -> busy remains 1.
- Mid-operation reset: mark r2, write r4=0x00AA, then pulse rst_n=0 for 1 cycle -> ready drops; after the 16-cycle sweep, r4 reads 0 and rbusy for r2 is 0.
- With REGS_R0_ZERO_EN: write r0=0xFFFF and mark r0 -> r0 reads 0x0000 on all ports and rbusy=0; without the macro it reads 0xFFFF.
